// File: rtl/bank_seq_pkg.sv
// Shared types and constants for the register-bank sequencer: FSM states,
// opcodes, bank target codes and the Rn -> bank-code mapping.
package bank_seq_pkg;

    typedef enum logic [4:0] {
        ST_RST_PC,
        ST_IDLE,
        ST_F_A,
        ST_F_M,
        ST_F_INC,
        ST_DEC,
        ST_A_D1,
        ST_A_D2,
        ST_A_EX,
        ST_A_WB,
        ST_O_A,
        ST_O_M,
        ST_O_INC,
        ST_M_RD,
        ST_M_WR,
        ST_J_PC,
        ST_HALTED
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_MOV  = 4'h3;
    localparam logic [3:0] OP_ALU  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] BANK_PC     = 4'd0;
    localparam logic [3:0] BANK_AR     = 4'd1;
    localparam logic [3:0] BANK_ALUREG = 4'd2;
    localparam logic [3:0] BANK_IR     = 4'd3;
    localparam logic [3:0] BANK_D1     = 4'd4;
    localparam logic [3:0] BANK_D2     = 4'd5;
    localparam logic [3:0] BANK_R0     = 4'd6;
    localparam logic [3:0] BANK_DR     = 4'd14;
    localparam logic [3:0] BANK_RES2   = 4'd15;

    // General register Rn lives at bank code 6+n.
    function automatic logic [3:0] reg_code(input logic [2:0] n);
        return BANK_R0 + {1'b0, n};
    endfunction

endpackage

// File: rtl/bank_seq_outdec.sv
// Combinational control decoder: maps (state, IR, mem_ack) onto every bank
// control line. Anything a state does not drive falls back to the idle idiom
// where RES2 rewrites itself from the internal bus.
module bank_seq_outdec
    import bank_seq_pkg::*;
(
    input  state_t      state,
    input  logic [15:0] ir,
    input  logic        mem_ack,
    output logic [3:0]  sel_ip,
    output logic [3:0]  sel_op,
    output logic        trnsfr,
    output logic        en_pc,
    output logic        incpc,
    output logic        rstpc,
    output logic        alu_en,
    output logic [2:0]  alu_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic        halted
);

    logic [3:0] op;
    logic [3:0] rd_code;
    logic [3:0] rs1_code;
    logic [3:0] rs2_code;
    logic [2:0] func;

    assign op       = ir[15:12];
    assign rd_code  = reg_code(ir[11:9]);
    assign rs1_code = reg_code(ir[8:6]);
    assign rs2_code = reg_code(ir[5:3]);
    assign func     = ir[2:0];

    // Per-state drive of the bank controls on top of the idle defaults
    always_comb begin
        sel_ip  = BANK_RES2;
        sel_op  = BANK_RES2;
        trnsfr  = 1'b0;
        en_pc   = 1'b0;
        incpc   = 1'b0;
        rstpc   = 1'b0;
        alu_en  = 1'b0;
        alu_op  = 3'd0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        halted  = 1'b0;
        case (state)
            ST_RST_PC: begin
                sel_ip = BANK_PC;
                rstpc  = 1'b1;
            end
            ST_F_A, ST_O_A: begin
                sel_op = BANK_PC;
                sel_ip = BANK_AR;
            end
            ST_F_M: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    trnsfr = 1'b1;
                    sel_ip = BANK_IR;
                end
            end
            ST_F_INC, ST_O_INC: begin
                sel_ip = BANK_PC;
                en_pc  = 1'b1;
                incpc  = 1'b1;
            end
            ST_DEC: begin
                if (op == OP_MOV) begin
                    sel_op = rs1_code;
                    sel_ip = rd_code;
                end
            end
            ST_A_D1: begin
                sel_op = rs1_code;
                sel_ip = BANK_D1;
            end
            ST_A_D2: begin
                sel_op = rs2_code;
                sel_ip = BANK_D2;
            end
            ST_A_EX: begin
                alu_en = 1'b1;
                alu_op = func;
            end
            ST_A_WB: begin
                sel_op = BANK_ALUREG;
                sel_ip = rd_code;
            end
            ST_O_M: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    trnsfr = 1'b1;
                    sel_ip = BANK_AR;
                end
            end
            ST_M_RD: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    trnsfr = 1'b1;
                    sel_ip = rd_code;
                end
            end
            ST_M_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                sel_op  = rs1_code;
            end
            ST_J_PC: begin
                sel_op = BANK_AR;
                sel_ip = BANK_PC;
                en_pc  = 1'b1;
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/bank_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-register bank.
// Holds only the FSM state and the sticky illegal-opcode flag; all bank
// controls come from the combinational decoder.
module bank_sequencer
    import bank_seq_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] ir,
    input  logic        mem_ack,
    output logic [3:0]  sel_ip,
    output logic [3:0]  sel_op,
    output logic        TRNSFR,
    output logic        en_pc,
    output logic        incpc,
    output logic        rstpc,
    output logic        ALUEN,
    output logic [2:0]  alu_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic        halted,
    output logic        illegal
);

    state_t     state_q;
    state_t     state_d;
    logic       illegal_q;
    logic       illegal_d;
    logic [3:0] op;
    logic       dec_alu_en;
    logic       dec_mem_req;
    logic       dec_mem_we;

    assign op = ir[15:12];

    bank_seq_outdec u_outdec (
        .state   (state_q),
        .ir      (ir),
        .mem_ack (mem_ack),
        .sel_ip  (sel_ip),
        .sel_op  (sel_op),
        .trnsfr  (TRNSFR),
        .en_pc   (en_pc),
        .incpc   (incpc),
        .rstpc   (rstpc),
        .alu_en  (dec_alu_en),
        .alu_op  (alu_op),
        .mem_req (dec_mem_req),
        .mem_we  (dec_mem_we),
        .halted  (halted)
    );

    // Reset drops any in-flight request in the very cycle it is seen
    assign mem_req = dec_mem_req & ~rst;
    assign mem_we  = dec_mem_we & ~rst;
    assign ALUEN   = dec_alu_en & ~rst;
    assign illegal = illegal_q;

    // Next-state and illegal-flag logic
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_RST_PC: state_d = ST_IDLE;
            ST_IDLE:   if (run) state_d = ST_F_A;
            ST_F_A:    state_d = ST_F_M;
            ST_F_M:    if (mem_ack) state_d = ST_F_INC;
            ST_F_INC:  state_d = ST_DEC;
            ST_DEC: begin
                case (op)
                    OP_NOP, OP_MOV:       state_d = ST_F_A;
                    OP_ALU:               state_d = ST_A_D1;
                    OP_LD, OP_ST, OP_JMP: state_d = ST_O_A;
                    OP_HALT:              state_d = ST_HALTED;
                    default: begin
                        state_d   = ST_F_A;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_A_D1:   state_d = ST_A_D2;
            ST_A_D2:   state_d = ST_A_EX;
            ST_A_EX:   state_d = ST_A_WB;
            ST_A_WB:   state_d = ST_F_A;
            ST_O_A:    state_d = ST_O_M;
            ST_O_M:    if (mem_ack) state_d = (op == OP_JMP) ? ST_J_PC : ST_O_INC;
            ST_O_INC:  state_d = (op == OP_LD) ? ST_M_RD : ST_M_WR;
            ST_M_RD:   if (mem_ack) state_d = ST_F_A;
            ST_M_WR:   if (mem_ack) state_d = ST_F_A;
            ST_J_PC:   state_d = ST_F_A;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RST_PC;
        endcase
    end

    // State and sticky flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RST_PC;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // The bank's rstpc path can only load zero into the PC
    always_ff @(posedge clk) begin
        assert (RESET_VECTOR == 16'h0000);
    end

endmodule

// File: tb/tb_bank_sequencer.sv
// Directed bench for bank_sequencer: a behavioural register bank and memory
// are driven by the DUT controls so program effects (PC, registers) can be
// checked alongside the control lines themselves.
module tb_bank_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [15:0] ir;
    logic        mem_ack;
    logic [3:0]  sel_ip;
    logic [3:0]  sel_op;
    logic        TRNSFR;
    logic        en_pc;
    logic        incpc;
    logic        rstpc;
    logic        ALUEN;
    logic [2:0]  alu_op;
    logic        mem_req;
    logic        mem_we;
    logic        halted;
    logic        illegal;

    int checks = 0;
    int failures = 0;

    logic [15:0] bank [16];
    logic [15:0] mem [256];
    logic [15:0] din;
    logic [15:0] bus;
    int unsigned wait_cfg = 0;
    int unsigned wait_cnt = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;

    bank_sequencer #(.RESET_VECTOR(16'h0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .ir      (ir),
        .mem_ack (mem_ack),
        .sel_ip  (sel_ip),
        .sel_op  (sel_op),
        .TRNSFR  (TRNSFR),
        .en_pc   (en_pc),
        .incpc   (incpc),
        .rstpc   (rstpc),
        .ALUEN   (ALUEN),
        .alu_op  (alu_op),
        .mem_req (mem_req),
        .mem_we  (mem_we),
        .halted  (halted),
        .illegal (illegal)
    );

    assign ir      = bank[3];
    assign din     = mem[bank[1][7:0]];
    assign mem_ack = mem_req && (wait_cnt >= wait_cfg);
    assign bus     = TRNSFR ? din : bank[sel_op];

    // Behavioural bank, ALU (add only) and memory wait counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
        if (ALUEN && alu_op == 3'd0) bank[2] <= bank[4] + bank[5];
        if (sel_ip == 4'd0) begin
            if (rstpc)      bank[0] <= 16'h0000;
            else if (en_pc) bank[0] <= incpc ? bank[0] + 16'd1 : bus;
        end else begin
            bank[sel_ip] <= bus;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    // Leaves the DUT in RST_PC with rst released and run high
    task automatic start_run();
        rst = 1'b1; run = 1'b1; wait_cfg = 0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Advance to the next instruction-fetch completion (F_M with ack)
    task automatic wait_fetch(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (mem_req && mem_ack && sel_ip == 4'd3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        int unsigned c0;
        clear_mem();
        rst = 1'b1; run = 1'b0; wait_cfg = 0;
        tick(); tick();
        checks++; if (rstpc !== 1'b1) begin failures++; $display("FAIL reset_rstpc: got %0b want 1", rstpc); end
        checks++; if ({sel_op, sel_ip} !== 8'hF0) begin failures++; $display("FAIL reset_sel: got %h want f0", {sel_op, sel_ip}); end
        checks++; if ({mem_req, ALUEN, halted, illegal} !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b want 0000", {mem_req, ALUEN, halted, illegal}); end
        rst = 1'b0;
        tick(); // IDLE
        checks++; if (bank[0] !== 16'h0000 || rstpc !== 1'b0) begin failures++; $display("FAIL idle_pc: pc=%h rstpc=%0b want 0000/0", bank[0], rstpc); end
        tick(); // IDLE holds while run is low
        checks++; if ({sel_op, sel_ip} !== 8'hFF) begin failures++; $display("FAIL idle_hold: got %h want ff", {sel_op, sel_ip}); end
        run = 1'b1;
        tick(); // F_A
        checks++; if ({sel_op, sel_ip, mem_req} !== 9'h002) begin failures++; $display("FAIL fetch_fa: got %h want 002", {sel_op, sel_ip, mem_req}); end
        tick(); // F_M
        checks++; if ({mem_req, mem_we, TRNSFR, sel_ip} !== 7'b1010011) begin failures++; $display("FAIL fetch_fm: got %b want 1010011", {mem_req, mem_we, TRNSFR, sel_ip}); end
        c0 = cyc;
        tick(); // F_INC
        checks++; if ({sel_ip, en_pc, incpc} !== 6'b000011) begin failures++; $display("FAIL fetch_inc: got %b want 000011", {sel_ip, en_pc, incpc}); end
        tick(); // DEC
        checks++; if (bank[0] !== 16'h0001) begin failures++; $display("FAIL nop_pc: got %h want 0001", bank[0]); end
        wait_fetch(20, ok);
        checks++; if (!ok || (cyc - c0) != 4) begin failures++; $display("FAIL nop_cycles: ok=%0b got %0d want 4", ok, cyc - c0); end
    endtask

    task automatic test_alu();
        bit ok;
        int unsigned c0;
        int pulses;
        clear_mem();
        mem[0] = 16'h1200; mem[1] = 16'h0080;   // LD R1,[80]
        mem[2] = 16'h1400; mem[3] = 16'h0081;   // LD R2,[81]
        mem[4] = 16'h4650;                      // R3 = R1 + R2
        mem[5] = 16'hF000;
        mem[8'h80] = 16'd5; mem[8'h81] = 16'd7;
        start_run();
        wait_fetch(20, ok);
        c0 = cyc;
        run = 1'b0;  // execution must continue without run
        wait_fetch(40, ok);
        checks++; if (!ok || (cyc - c0) != 8) begin failures++; $display("FAIL ld_cycles: ok=%0b got %0d want 8", ok, cyc - c0); end
        wait_fetch(40, ok);
        checks++; if (!ok || bank[7] !== 16'd5 || bank[8] !== 16'd7) begin failures++; $display("FAIL ld_regs: R1=%h R2=%h want 0005/0007", bank[7], bank[8]); end
        c0 = cyc;
        pulses = 0;
        tick(); tick(); // F_INC, DEC
        tick(); pulses += int'(ALUEN); // A_D1
        checks++; if ({sel_op, sel_ip} !== 8'h74) begin failures++; $display("FAIL alu_d1: got %h want 74", {sel_op, sel_ip}); end
        tick(); pulses += int'(ALUEN); // A_D2
        checks++; if ({sel_op, sel_ip} !== 8'h85) begin failures++; $display("FAIL alu_d2: got %h want 85", {sel_op, sel_ip}); end
        tick(); pulses += int'(ALUEN); // A_EX
        checks++; if (ALUEN !== 1'b1 || alu_op !== 3'd0) begin failures++; $display("FAIL alu_ex: aluen=%0b op=%0d want 1/0", ALUEN, alu_op); end
        tick(); pulses += int'(ALUEN); // A_WB
        checks++; if ({sel_op, sel_ip} !== 8'h29) begin failures++; $display("FAIL alu_wb: got %h want 29", {sel_op, sel_ip}); end
        tick(); pulses += int'(ALUEN); // F_A
        checks++; if (pulses != 1) begin failures++; $display("FAIL alu_pulses: got %0d want 1", pulses); end
        checks++; if (bank[9] !== 16'd12) begin failures++; $display("FAIL alu_result: R3=%h want 000c", bank[9]); end
        wait_fetch(20, ok);
        checks++; if (!ok || (cyc - c0) != 8) begin failures++; $display("FAIL alu_cycles: ok=%0b got %0d want 8", ok, cyc - c0); end
        tick(); tick(); tick(); // F_INC, DEC, HALTED
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL alu_halt: got %0b want 1", halted); end
    endtask

    task automatic test_ld_wait();
        bit ok;
        bit we_seen;
        int unsigned c0;
        int reqs;
        clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'h0090;   // LD R0,[90]
        mem[2] = 16'hF000;
        mem[8'h90] = 16'hBEEF;
        start_run();
        wait_fetch(20, ok);
        c0 = cyc;
        tick(); tick(); tick(); // F_INC, DEC, O_A
        tick(); // O_M
        checks++; if ({mem_req, TRNSFR, sel_ip} !== 6'b110001) begin failures++; $display("FAIL ld_om: got %b want 110001", {mem_req, TRNSFR, sel_ip}); end
        tick(); // O_INC
        checks++; if ({sel_ip, en_pc, incpc} !== 6'b000011) begin failures++; $display("FAIL ld_oinc: got %b want 000011", {sel_ip, en_pc, incpc}); end
        wait_cfg = 3;
        reqs = 0; we_seen = 1'b0; ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_req) reqs++;
            if (mem_we) we_seen = 1'b1;
            if (mem_ack) begin ok = 1'b1; break; end
        end
        checks++; if (!ok || reqs != 4 || we_seen) begin failures++; $display("FAIL ld_req_hold: ack=%0b reqs=%0d we=%0b want 1/4/0", ok, reqs, we_seen); end
        checks++; if ({TRNSFR, sel_ip} !== 5'b10110) begin failures++; $display("FAIL ld_mrd: got %b want 10110", {TRNSFR, sel_ip}); end
        wait_cfg = 0;
        tick(); // F_A
        checks++; if (bank[6] !== 16'hBEEF || bank[0] !== 16'h0002) begin failures++; $display("FAIL ld_data: R0=%h pc=%h want beef/0002", bank[6], bank[0]); end
        wait_fetch(20, ok);
        // F_A F_M F_INC DEC O_A O_M O_INC M_RD = 8 cycles, plus 3 wait cycles
        checks++; if (!ok || (cyc - c0) != 11) begin failures++; $display("FAIL ld_wait_cycles: ok=%0b got %0d want 11", ok, cyc - c0); end
    endtask

    task automatic test_jmp();
        bit ok;
        int unsigned c0;
        clear_mem();
        mem[0] = 16'h5000; mem[1] = 16'h0040;   // JMP 0040
        mem[8'h40] = 16'hF000;
        start_run();
        wait_fetch(20, ok);
        c0 = cyc;
        tick(); tick(); // F_INC, DEC
        tick(); // O_A
        checks++; if ({sel_op, sel_ip} !== 8'h01) begin failures++; $display("FAIL jmp_oa: got %h want 01", {sel_op, sel_ip}); end
        tick(); // O_M
        tick(); // J_PC, directly after O_M
        checks++; if ({sel_op, sel_ip, en_pc, incpc} !== 10'b0001000010) begin failures++; $display("FAIL jmp_jpc: got %b want 0001000010", {sel_op, sel_ip, en_pc, incpc}); end
        tick(); // F_A
        checks++; if (bank[0] !== 16'h0040 || sel_op !== 4'd0) begin failures++; $display("FAIL jmp_pc: pc=%h sel_op=%0d want 0040/0", bank[0], sel_op); end
        wait_fetch(20, ok);
        checks++; if (!ok || (cyc - c0) != 7) begin failures++; $display("FAIL jmp_cycles: ok=%0b got %0d want 7", ok, cyc - c0); end
        tick(); tick(); tick();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL jmp_target_halt: got %0b want 1", halted); end
    endtask

    task automatic test_illegal_halt();
        bit ok;
        bit req_seen;
        int unsigned c0;
        clear_mem();
        mem[0] = 16'h7000; mem[1] = 16'h0000; mem[2] = 16'hF000;
        start_run();
        wait_fetch(20, ok);
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_pre: got %0b want 0", illegal); end
        c0 = cyc;
        tick(); tick(); tick(); // F_INC, DEC, F_A
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_set: got %0b want 1", illegal); end
        wait_fetch(20, ok);
        checks++; if (!ok || (cyc - c0) != 4) begin failures++; $display("FAIL illegal_as_nop: ok=%0b got %0d want 4", ok, cyc - c0); end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (halted) begin ok = 1'b1; break; end
        end
        checks++; if (!ok || illegal !== 1'b1) begin failures++; $display("FAIL halt_reach: halted=%0b illegal=%0b want 1/1", ok, illegal); end
        req_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run = ~run;
            tick();
            if (mem_req || !halted) req_seen = 1'b1;
        end
        checks++; if (req_seen || {sel_op, sel_ip} !== 8'hFF) begin failures++; $display("FAIL halt_sticky: left=%0b sel=%h want 0/ff", req_seen, {sel_op, sel_ip}); end
        rst = 1'b1;
        tick();
        checks++; if ({illegal, halted, rstpc} !== 3'b001) begin failures++; $display("FAIL halt_rst: got %b want 001", {illegal, halted, rstpc}); end
        rst = 1'b0;
    endtask

    task automatic test_rst_mid_write();
        bit ok;
        clear_mem();
        mem[0] = 16'h2080; mem[1] = 16'h00A0;   // ST [A0] <- R2
        start_run();
        wait_fetch(20, ok);
        tick(); tick(); tick(); tick(); tick(); // F_INC, DEC, O_A, O_M, O_INC
        wait_cfg = 50;
        tick(); // M_WR
        checks++; if ({mem_req, mem_we, sel_op} !== 6'b111000) begin failures++; $display("FAIL st_mwr: got %b want 111000", {mem_req, mem_we, sel_op}); end
        tick(); // still waiting
        checks++; if ({mem_req, mem_we, sel_op} !== 6'b111000) begin failures++; $display("FAIL st_hold: got %b want 111000", {mem_req, mem_we, sel_op}); end
        rst = 1'b1;
        #1;
        checks++; if ({mem_req, mem_we} !== 2'b00) begin failures++; $display("FAIL st_rst_drop: got %b want 00", {mem_req, mem_we}); end
        tick(); // RST_PC
        checks++; if ({rstpc, sel_ip} !== 5'b10000) begin failures++; $display("FAIL st_rst_state: got %b want 10000", {rstpc, sel_ip}); end
        rst = 1'b0; wait_cfg = 0;
        tick(); // IDLE
        checks++; if ({rstpc, sel_op, sel_ip} !== 9'h0FF) begin failures++; $display("FAIL st_idle: got %h want 0ff", {rstpc, sel_op, sel_ip}); end
        tick(); // F_A
        checks++; if ({sel_op, sel_ip} !== 8'h01) begin failures++; $display("FAIL st_restart: got %h want 01", {sel_op, sel_ip}); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ld_wait();
        test_jmp();
        test_illegal_halt();
        test_rst_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
